// File: rtl/pipeline_controller_if.sv
// Control-path bus between the MIPS datapath and the pipelined main controller.
// The master side (datapath/hazard unit) supplies the decode-stage instruction
// fields and hazard/flag inputs. The slave side (controller) returns the
// stage-aligned control bundle.
interface pipeline_controller_if #(parameter int CNT_W = 16);
   logic [5:0]       Opcode;
   logic [5:0]       Funct;
   logic             FlushE;
   logic             ZeroM;
   logic             JumpD;
   logic             IllegalD;
   logic             RegWriteE;
   logic             MemToRegE;
   logic             RegDstE;
   logic             ALUSrcE;
   logic [2:0]       ALUControlE;
   logic             MemWriteM;
   logic             RegWriteM;
   logic             PCSrcM;
   logic             RegWriteW;
   logic             MemToRegW;
   logic [CNT_W-1:0] RetireCount;

   modport master (
      output Opcode, Funct, FlushE, ZeroM,
      input  JumpD, IllegalD, RegWriteE, MemToRegE, RegDstE, ALUSrcE, ALUControlE,
             MemWriteM, RegWriteM, PCSrcM, RegWriteW, MemToRegW, RetireCount
   );

   modport slave (
      input  Opcode, Funct, FlushE, ZeroM,
      output JumpD, IllegalD, RegWriteE, MemToRegE, RegDstE, ALUSrcE, ALUControlE,
             MemWriteM, RegWriteM, PCSrcM, RegWriteW, MemToRegW, RetireCount
   );
endinterface

// File: rtl/pipeline_controller.sv
// Pipelined main controller for the 5-stage MIPS core.
// Decodes the D-stage instruction, carries the control bundle through E/M/W,
// squashes wrong-path instructions on a taken branch and counts retirements.
// Every D-stage slot is treated as a valid instruction; only flushes make bubbles.
module pipeline_controller #(
   parameter int CNT_W = 16
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_controller_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src;
      logic       branch;
      logic       mem_write;
      logic       mem_to_reg;
      logic [2:0] alu_ctrl;
   } ctrl_t;

   ctrl_t            ctrl_d;
   ctrl_t            ctrl_e;
   logic             jump_d;
   logic             illegal_d;

   logic             valid_m;
   logic             reg_write_m;
   logic             mem_to_reg_m;
   logic             mem_write_m;
   logic             branch_m;
   logic             pcsrc_m;

   logic             valid_w;
   logic             reg_write_w;
   logic             mem_to_reg_w;
   logic [CNT_W-1:0] retire_cnt;

   // Main decoder: unknown opcodes/functs decode to an all-zero bundle but still retire.
   always_comb begin
      ctrl_d       = '0;
      ctrl_d.valid = 1'b1;
      jump_d       = 1'b0;
      illegal_d    = 1'b0;
      case (bus.Opcode)
         6'b000000: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.reg_dst   = 1'b1;
            case (bus.Funct)
               6'b100000: ctrl_d.alu_ctrl = 3'b010;
               6'b100010: ctrl_d.alu_ctrl = 3'b110;
               6'b100100: ctrl_d.alu_ctrl = 3'b000;
               6'b100101: ctrl_d.alu_ctrl = 3'b001;
               6'b101010: ctrl_d.alu_ctrl = 3'b111;
               default: begin
                  ctrl_d.reg_write = 1'b0;
                  ctrl_d.reg_dst   = 1'b0;
                  illegal_d        = 1'b1;
               end
            endcase
         end
         6'b100011: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.alu_ctrl   = 3'b010;
         end
         6'b101011: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_ctrl  = 3'b010;
         end
         6'b000100: begin
            ctrl_d.branch   = 1'b1;
            ctrl_d.alu_ctrl = 3'b110;
         end
         6'b001000: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.alu_ctrl  = 3'b010;
         end
         6'b000010: jump_d = 1'b1;
         default:   illegal_d = 1'b1;
      endcase
   end

   assign pcsrc_m = branch_m & bus.ZeroM;

   // E stage: bubble on hazard flush or taken branch (both together still one bubble).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ctrl_e <= '0;
      else if (bus.FlushE | pcsrc_m)
         ctrl_e <= '0;
      else
         ctrl_e <= ctrl_d;
   end

   // M stage: a taken branch squashes the wrong-path instruction coming out of E.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_m      <= 1'b0;
         reg_write_m  <= 1'b0;
         mem_to_reg_m <= 1'b0;
         mem_write_m  <= 1'b0;
         branch_m     <= 1'b0;
      end else if (pcsrc_m) begin
         valid_m      <= 1'b0;
         reg_write_m  <= 1'b0;
         mem_to_reg_m <= 1'b0;
         mem_write_m  <= 1'b0;
         branch_m     <= 1'b0;
      end else begin
         valid_m      <= ctrl_e.valid;
         reg_write_m  <= ctrl_e.reg_write;
         mem_to_reg_m <= ctrl_e.mem_to_reg;
         mem_write_m  <= ctrl_e.mem_write;
         branch_m     <= ctrl_e.branch;
      end
   end

   // W stage: always takes M, so the branch itself completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_w      <= 1'b0;
         reg_write_w  <= 1'b0;
         mem_to_reg_w <= 1'b0;
      end else begin
         valid_w      <= valid_m;
         reg_write_w  <= reg_write_m;
         mem_to_reg_w <= mem_to_reg_m;
      end
   end

   // Retirement counter: one per valid instruction leaving W, wraps silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         retire_cnt <= '0;
      else if (valid_w)
         retire_cnt <= retire_cnt + CNT_ONE;
   end

   assign bus.JumpD       = jump_d;
   assign bus.IllegalD    = illegal_d;
   assign bus.RegWriteE   = ctrl_e.reg_write;
   assign bus.MemToRegE   = ctrl_e.mem_to_reg;
   assign bus.RegDstE     = ctrl_e.reg_dst;
   assign bus.ALUSrcE     = ctrl_e.alu_src;
   assign bus.ALUControlE = ctrl_e.alu_ctrl;
   assign bus.MemWriteM   = mem_write_m;
   assign bus.RegWriteM   = reg_write_m;
   assign bus.PCSrcM      = pcsrc_m;
   assign bus.RegWriteW   = reg_write_w;
   assign bus.MemToRegW   = mem_to_reg_w;
   assign bus.RetireCount = retire_cnt;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: decode, stage latency, branch squash,
// hazard flush, async reset and retirement-counter wrap.
module tb_pipeline_controller;

   localparam int CNT_W = 16;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BAD  = 6'b111111;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   pipeline_controller_if #(.CNT_W(CNT_W)) bus ();

   pipeline_controller #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [5:0] op, input logic [5:0] fn);
      bus.Opcode = op;
      bus.Funct  = fn;
   endtask

   // Called 1 ns after a rising edge; pulse completes well before the next edge.
   task automatic rst_pulse();
      #1 reset = 1'b0;
      #1 reset = 1'b1;
   endtask

   initial begin
      reset      = 1'b0;
      bus.Opcode = OP_R;
      bus.Funct  = FN_ADD;
      bus.FlushE = 1'b0;
      bus.ZeroM  = 1'b0;
      #3;
      check("rst_regwrite_e", bus.RegWriteE, 0);
      check("rst_alu_ctrl_e", bus.ALUControlE, 0);
      check("rst_memwrite_m", bus.MemWriteM, 0);
      check("rst_regwrite_w", bus.RegWriteW, 0);
      check("rst_count", bus.RetireCount, 0);
      tick();
      reset = 1'b1;

      // Async reset mid-stream with lw in M
      instr(OP_LW, 6'd0);
      repeat (5) tick();
      check("t1_pre_memtoreg_w", bus.MemToRegW, 1);
      check("t1_pre_regwrite_w", bus.RegWriteW, 1);
      check("t1_pre_regwrite_m", bus.RegWriteM, 1);
      check("t1_pre_count", bus.RetireCount, 2);
      #2 reset = 1'b0;
      #1;
      check("t1_memtoreg_w", bus.MemToRegW, 0);
      check("t1_regwrite_w", bus.RegWriteW, 0);
      check("t1_memwrite_m", bus.MemWriteM, 0);
      check("t1_regwrite_m", bus.RegWriteM, 0);
      check("t1_regwrite_e", bus.RegWriteE, 0);
      check("t1_count", bus.RetireCount, 0);
      reset = 1'b1;
      tick();

      // R-type add latency and retirement
      rst_pulse();
      instr(OP_R, FN_ADD);
      tick();
      check("t2_regdst_e", bus.RegDstE, 1);
      check("t2_alusrc_e", bus.ALUSrcE, 0);
      check("t2_aluctrl_e", bus.ALUControlE, 3'b010);
      check("t2_regwrite_e", bus.RegWriteE, 1);
      instr(OP_SW, 6'd0);
      tick();
      tick();
      check("t2_regwrite_w", bus.RegWriteW, 1);
      check("t2_memtoreg_w", bus.MemToRegW, 0);
      check("t2_count_c3", bus.RetireCount, 0);
      tick();
      check("t2_count_c4", bus.RetireCount, 1);

      // ALU control table
      rst_pulse();
      instr(OP_R, FN_SUB);  tick(); check("alu_sub", bus.ALUControlE, 3'b110);
      instr(OP_R, FN_AND);  tick(); check("alu_and", bus.ALUControlE, 3'b000);
      instr(OP_R, FN_OR);   tick(); check("alu_or", bus.ALUControlE, 3'b001);
      instr(OP_R, FN_SLT);  tick(); check("alu_slt", bus.ALUControlE, 3'b111);
      instr(OP_ADDI, 6'd0); tick();
      check("addi_aluctrl", bus.ALUControlE, 3'b010);
      check("addi_alusrc", bus.ALUSrcE, 1);
      check("addi_regdst", bus.RegDstE, 0);
      check("addi_regwrite", bus.RegWriteE, 1);
      instr(OP_BEQ, 6'd0);  tick();
      check("beq_aluctrl", bus.ALUControlE, 3'b110);
      check("beq_regwrite", bus.RegWriteE, 0);

      // lw then sw back-to-back
      rst_pulse();
      instr(OP_LW, 6'd0);
      tick();
      check("t3_memtoreg_e", bus.MemToRegE, 1);
      check("t3_alusrc_e", bus.ALUSrcE, 1);
      instr(OP_SW, 6'd0);
      tick();
      check("t3_memwrite_m_c2", bus.MemWriteM, 0);
      check("t3_regwrite_m_c2", bus.RegWriteM, 1);
      check("t3_sw_regwrite_e", bus.RegWriteE, 0);
      instr(OP_R, FN_ADD);
      tick();
      check("t3_memwrite_m_c3", bus.MemWriteM, 1);
      check("t3_memtoreg_w_c3", bus.MemToRegW, 1);
      check("t3_regwrite_w_c3", bus.RegWriteW, 1);

      // Taken beq squashes the next two instructions
      rst_pulse();
      instr(OP_BEQ, 6'd0);
      tick();
      instr(OP_R, FN_ADD);
      tick();
      check("t4_pcsrc_zero0", bus.PCSrcM, 0);
      bus.ZeroM = 1'b1;
      #1;
      check("t4_pcsrc", bus.PCSrcM, 1);
      tick();
      bus.ZeroM = 1'b0;
      check("t4_regwrite_e_c3", bus.RegWriteE, 0);
      check("t4_regwrite_m_c3", bus.RegWriteM, 0);
      check("t4_pcsrc_c3", bus.PCSrcM, 0);
      tick();
      check("t4_regwrite_w_c4", bus.RegWriteW, 0);
      check("t4_target_regwrite_e", bus.RegWriteE, 1);
      tick();
      check("t4_regwrite_w_c5", bus.RegWriteW, 0);
      tick();
      check("t4_count_c6", bus.RetireCount, 1);
      check("t4_target_regwrite_w", bus.RegWriteW, 1);

      // FlushE on an addi
      rst_pulse();
      instr(OP_ADDI, 6'd0);
      bus.FlushE = 1'b1;
      tick();
      bus.FlushE = 1'b0;
      check("t5_regwrite_e", bus.RegWriteE, 0);
      check("t5_alusrc_e", bus.ALUSrcE, 0);
      instr(OP_SW, 6'd0);
      tick();
      tick();
      check("t5_regwrite_w", bus.RegWriteW, 0);
      tick();
      check("t5_count_c4", bus.RetireCount, 0);
      tick();
      check("t5_count_c5", bus.RetireCount, 1);

      // FlushE and PCSrcM on the same edge
      rst_pulse();
      instr(OP_BEQ, 6'd0);
      tick();
      instr(OP_R, FN_ADD);
      tick();
      bus.ZeroM  = 1'b1;
      bus.FlushE = 1'b1;
      tick();
      bus.ZeroM  = 1'b0;
      bus.FlushE = 1'b0;
      check("t5b_regwrite_e", bus.RegWriteE, 0);
      check("t5b_regwrite_m", bus.RegWriteM, 0);
      tick();
      check("t5b_target_regwrite_e", bus.RegWriteE, 1);
      check("t5b_regwrite_w_c4", bus.RegWriteW, 0);
      tick();
      check("t5b_regwrite_w_c5", bus.RegWriteW, 0);
      tick();
      check("t5b_count_c6", bus.RetireCount, 1);

      // Illegal / jump decode, illegal retires as NOP
      rst_pulse();
      instr(OP_BAD, 6'd0);
      #1;
      check("t6_illegal", bus.IllegalD, 1);
      check("t6_illegal_jump", bus.JumpD, 0);
      instr(OP_J, 6'd0);
      #1;
      check("t6_jump", bus.JumpD, 1);
      check("t6_jump_illegal", bus.IllegalD, 0);
      instr(OP_R, 6'b000000);
      #1;
      check("t6_bad_funct", bus.IllegalD, 1);
      instr(OP_BAD, 6'd0);
      tick();
      check("t6_regwrite_e", bus.RegWriteE, 0);
      check("t6_memtoreg_e", bus.MemToRegE, 0);
      check("t6_aluctrl_e", bus.ALUControlE, 0);
      tick();
      check("t6_memwrite_m", bus.MemWriteM, 0);
      tick();
      check("t6_regwrite_w", bus.RegWriteW, 0);
      check("t6_memtoreg_w", bus.MemToRegW, 0);
      tick();
      check("t6_count", bus.RetireCount, 1);

      // Counter wrap FFFF -> 0000
      rst_pulse();
      instr(OP_R, FN_ADD);
      repeat (65538) tick();
      check("wrap_ffff", bus.RetireCount, 16'hFFFF);
      tick();
      check("wrap_0000", bus.RetireCount, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
